// File: rtl/cv32e40px_aligner_buf_if.sv
// Fetch-side, issue-side and redirect signals of the instruction aligner.
// slave = the aligner, master = the surrounding IF stage.
interface cv32e40px_aligner_buf_if #(
  parameter int FETCH_WIDTH = 32
) ();
  logic                   fetch_valid_i;
  logic                   fetch_ready_o;
  logic [FETCH_WIDTH-1:0] fetch_rdata_i;
  logic                   instr_valid_o;
  logic                   instr_ready_i;
  logic [31:0]            instr_o;
  logic                   instr_compressed_o;
  logic [31:0]            pc_o;
  logic                   branch_i;
  logic [31:0]            branch_addr_i;
  logic                   hwlp_update_pc_i;
  logic [31:0]            hwlp_addr_i;

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, instr_ready_i,
           branch_i, branch_addr_i, hwlp_update_pc_i, hwlp_addr_i,
    output fetch_ready_o, instr_valid_o, instr_o, instr_compressed_o, pc_o
  );

  modport master (
    output fetch_valid_i, fetch_rdata_i, instr_ready_i,
           branch_i, branch_addr_i, hwlp_update_pc_i, hwlp_addr_i,
    input  fetch_ready_o, instr_valid_o, instr_o, instr_compressed_o, pc_o
  );
endinterface

// File: rtl/cv32e40px_aligner_buf.sv
// Halfword-buffered instruction aligner: takes FETCH_WIDTH-bit fetch words and
// issues one aligned RV32/RV32C instruction per valid/ready handshake.
module cv32e40px_aligner_buf #(
  parameter int FETCH_WIDTH = 32,
  parameter int BUF_HW      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cv32e40px_aligner_buf_if.slave  bus
);
  localparam int FETCH_HW = FETCH_WIDTH / 16;
  localparam int CW       = $clog2(BUF_HW + 1);
  localparam int DW       = $clog2(FETCH_HW);
  localparam int BW       = $clog2(FETCH_WIDTH / 8);
  localparam int EW       = $clog2(BUF_HW + 2);

  if (!(FETCH_WIDTH == 32 || FETCH_WIDTH == 64)) begin : g_bad_fw
    $error("cv32e40px_aligner_buf: FETCH_WIDTH must be 32 or 64");
  end
  if (BUF_HW < FETCH_HW + 1) begin : g_bad_buf
    $error("cv32e40px_aligner_buf: BUF_HW must be >= FETCH_HW+1");
  end

  logic [BUF_HW-1:0][15:0] buf_q, buf_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             pc_q, pc_d;
  logic [31:0]             hwlp_addr_q, hwlp_addr_d;
  logic [DW-1:0]           drop_q, drop_d;
  logic                    hwlp_pend_q, hwlp_pend_d;

  logic                    head_c, instr_valid, fetch_ready, hs, acc;
  logic [FETCH_HW-1:0][15:0] fhw;
  logic [BUF_HW+1:0][15:0]   ext;

  // ext pads the buffer with two zero halfwords so a pop of up to 2 never indexes out of range
  assign fhw = bus.fetch_rdata_i;
  assign ext = {32'h0, buf_q};

  assign head_c      = buf_q[0][1:0] != 2'b11;
  assign instr_valid = ((cnt_q != '0) && head_c) || (int'(cnt_q) >= 2);
  assign fetch_ready = (BUF_HW - int'(cnt_q)) >= FETCH_HW;

  // a branch discards both the incoming word and the outgoing handshake
  assign hs  = instr_valid & bus.instr_ready_i & ~bus.branch_i;
  assign acc = bus.fetch_valid_i & fetch_ready & ~bus.branch_i;

  assign bus.fetch_ready_o      = fetch_ready;
  assign bus.instr_valid_o      = instr_valid;
  assign bus.instr_compressed_o = (cnt_q != '0) && head_c;
  assign bus.instr_o            = ((cnt_q != '0) && head_c) ? {16'h0, buf_q[0]}
                                                            : {buf_q[1], buf_q[0]};
  assign bus.pc_o               = pc_q;

  always_comb begin
    int pop, base, src, idx;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    hwlp_addr_d = hwlp_addr_q;
    hwlp_pend_d = hwlp_pend_q;
    drop_d      = drop_q;
    pop         = 0;
    base        = 0;
    src         = 0;
    idx         = 0;

    if (hs) pop = head_c ? 1 : 2;
    base = int'(cnt_q) - pop;

    // shift out the popped halfwords, then land the kept fetch halfwords right after the survivors
    for (int i = 0; i < BUF_HW; i++) begin
      idx      = i + pop;
      buf_d[i] = ext[idx[EW-1:0]];
      src      = i - base + int'(drop_q);
      if (acc && (i >= base) && (src < FETCH_HW)) buf_d[i] = fhw[src[DW-1:0]];
    end
    cnt_d = CW'(base + (acc ? (FETCH_HW - int'(drop_q)) : 0));
    if (acc) drop_d = '0;

    if (hs) begin
      if (bus.hwlp_update_pc_i) begin
        pc_d = bus.hwlp_addr_i;
      end else if (hwlp_pend_q) begin
        pc_d        = hwlp_addr_q;
        hwlp_pend_d = 1'b0;
      end else begin
        pc_d = pc_q + (head_c ? 32'd2 : 32'd4);
      end
    end else if (bus.hwlp_update_pc_i) begin
      hwlp_addr_d = bus.hwlp_addr_i;
      hwlp_pend_d = 1'b1;
    end

    if (bus.branch_i) begin
      buf_d       = '0;
      cnt_d       = '0;
      pc_d        = {bus.branch_addr_i[31:1], 1'b0};
      drop_d      = bus.branch_addr_i[BW-1:1];
      hwlp_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      pc_q        <= '0;
      hwlp_addr_q <= '0;
      hwlp_pend_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      hwlp_addr_q <= hwlp_addr_d;
      hwlp_pend_q <= hwlp_pend_d;
      drop_q      <= drop_d;
    end
  end

`ifndef SYNTHESIS
  // only one hardware-loop redirect may be outstanding at a time
  a_hwlp_single: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(bus.hwlp_update_pc_i && hwlp_pend_q));
`endif
endmodule
